// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter and handshake sequencer for the peripheral io_* bus.
// Define PBA_TIMEOUT_EN to add an ACCESS watchdog that ends a stalled transfer with mX_err.
module periph_bus_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            pclk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_write,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [1:0]      m0_byte_size,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_ack,
    output logic            m0_err,

    input  logic            m1_req,
    input  logic            m1_write,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [1:0]      m1_byte_size,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_ack,
    output logic            m1_err,

    output logic [XLEN-1:0] io_addr,
    output logic            io_read,
    output logic            io_write,
    output logic [XLEN-1:0] io_wdata,
    output logic [1:0]      io_byte_size,
    output logic            read_ready,
    input  logic [XLEN-1:0] io_rdata,
    input  logic            io_ready,

    output logic            busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("periph_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef PBA_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Every flop of the block lives in one record so reset and hold-by-default stay uniform.
    typedef struct packed {
        state_t               state;
        logic                 last_grant;
        logic [XLEN-1:0]      addr;
        logic [XLEN-1:0]      wdata;
        logic [1:0]           size;
        logic                 rd;
        logic                 wr;
        logic                 read_ready;
        logic [1:0][XLEN-1:0] rdata;
        logic [1:0]           ack;
`ifdef PBA_TIMEOUT_EN
        logic [1:0]           err;
        logic [CNT_W-1:0]     cnt;
`endif
    } regs_t;

    regs_t r;
    regs_t nxt;
    logic  gnt;
    logic  gnt_write;

    always_ff @(posedge pclk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r            <= '0;
            r.last_grant <= 1'b1;
        end else begin
            r <= nxt;
        end
    end

    always_comb begin
        // NOTE: nxt starts as a copy of r so every path assigns every field and no latch is inferred.
        nxt       = r;
        nxt.ack   = '0;
`ifdef PBA_TIMEOUT_EN
        nxt.err   = '0;
`endif
        gnt       = 1'b0;
        gnt_write = 1'b0;

        case (r.state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the master that was not served last wins.
                    gnt            = (m0_req && m1_req) ? ~r.last_grant : m1_req;
                    gnt_write      = gnt ? m1_write : m0_write;
                    nxt.last_grant = gnt;
                    nxt.addr       = gnt ? m1_addr      : m0_addr;
                    nxt.wdata      = gnt ? m1_wdata     : m0_wdata;
                    nxt.size       = gnt ? m1_byte_size : m0_byte_size;
                    nxt.rd         = ~gnt_write;
                    nxt.wr         = gnt_write;
                    nxt.state      = ACCESS;
`ifdef PBA_TIMEOUT_EN
                    nxt.cnt        = '0;
`endif
                end
            end

            ACCESS: begin
                if (io_ready) begin
                    if (!r.wr) begin
                        nxt.rdata[r.last_grant] = io_rdata;
                    end
                    nxt.ack[r.last_grant] = 1'b1;
                    nxt.rd                = 1'b0;
                    nxt.wr                = 1'b0;
                    nxt.read_ready        = 1'b1;
                    nxt.state             = RELEASE;
                end
`ifdef PBA_TIMEOUT_EN
                else if (r.cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Watchdog expiry: error ack, no read_ready handshake.
                    nxt.rdata[r.last_grant] = '0;
                    nxt.ack[r.last_grant]   = 1'b1;
                    nxt.err[r.last_grant]   = 1'b1;
                    nxt.rd                  = 1'b0;
                    nxt.wr                  = 1'b0;
                    nxt.state               = IDLE;
                end else begin
                    nxt.cnt = r.cnt + CNT_W'(1);
                end
`endif
            end

            RELEASE: begin
                if (!io_ready) begin
                    nxt.read_ready = 1'b0;
                    nxt.state      = IDLE;
                end
            end

            default: begin
                nxt.state = IDLE;
            end
        endcase
    end

    assign io_addr      = r.addr;
    assign io_wdata     = r.wdata;
    assign io_byte_size = r.size;
    assign io_read      = r.rd;
    assign io_write     = r.wr;
    assign read_ready   = r.read_ready;
    assign m0_rdata     = r.rdata[0];
    assign m1_rdata     = r.rdata[1];
    assign m0_ack       = r.ack[0];
    assign m1_ack       = r.ack[1];
    assign busy         = (r.state != IDLE);

`ifdef PBA_TIMEOUT_EN
    assign m0_err = r.err[0];
    assign m1_err = r.err[1];
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: directed steps plus a randomized phase
// checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;

    localparam int XLEN = 32;
    localparam int TOUT = 8;

    typedef struct {
        logic            req;
        logic            write;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [1:0]      size;
    } master_t;

    logic            pclk = 1'b0;
    logic            rst;
    master_t         mst [2];

    logic            m0_req, m0_write, m1_req, m1_write;
    logic [XLEN-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]      m0_byte_size, m1_byte_size;
    logic [XLEN-1:0] m0_rdata, m1_rdata;
    logic            m0_ack, m1_ack, m0_err, m1_err;
    logic [XLEN-1:0] io_addr, io_wdata, io_rdata;
    logic [1:0]      io_byte_size;
    logic            io_read, io_write, read_ready, io_ready, busy;

    int              checks   = 0;
    int              failures = 0;
    int              model_last;
    logic [XLEN-1:0] exp_rdata [2];

    assign m0_req       = mst[0].req;
    assign m0_write     = mst[0].write;
    assign m0_addr      = mst[0].addr;
    assign m0_wdata     = mst[0].wdata;
    assign m0_byte_size = mst[0].size;
    assign m1_req       = mst[1].req;
    assign m1_write     = mst[1].write;
    assign m1_addr      = mst[1].addr;
    assign m1_wdata     = mst[1].wdata;
    assign m1_byte_size = mst[1].size;

    always #5 pclk = ~pclk;

    periph_bus_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TOUT)) dut (
        .pclk(pclk), .rst(rst),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_byte_size(m0_byte_size), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_byte_size(m1_byte_size), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .io_addr(io_addr), .io_read(io_read), .io_write(io_write), .io_wdata(io_wdata),
        .io_byte_size(io_byte_size), .read_ready(read_ready), .io_rdata(io_rdata),
        .io_ready(io_ready), .busy(busy)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic logic ack_of(input int i);
        return (i == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic err_of(input int i);
        return (i == 0) ? m0_err : m1_err;
    endfunction

    function automatic logic [XLEN-1:0] rdata_of(input int i);
        return (i == 0) ? m0_rdata : m1_rdata;
    endfunction

    // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
    function automatic int pick();
        if (mst[0].req && mst[1].req) return (model_last == 0) ? 1 : 0;
        if (mst[1].req) return 1;
        return 0;
    endfunction

    task automatic new_req(input int i);
        mst[i].req   = 1'b1;
        mst[i].write = 1'($urandom_range(1, 0));
        mst[i].addr  = $urandom;
        mst[i].wdata = $urandom;
        mst[i].size  = 2'($urandom_range(3, 0));
    endtask

    task automatic check_rdata(input string tag);
        check_word({tag, "_m0_rdata"}, m0_rdata, exp_rdata[0]);
        check_word({tag, "_m1_rdata"}, m1_rdata, exp_rdata[1]);
    endtask

    task automatic check_quiet(input string tag);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_strobe"}, io_read | io_write, 1'b0);
        check_bit({tag, "_read_ready"}, read_ready, 1'b0);
        check_bit({tag, "_acks"}, m0_ack | m1_ack, 1'b0);
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        mst[0].req = 1'b0;
        mst[1].req = 1'b0;
        io_ready   = 1'b0;
        tick();
        check_quiet("rst");
        check_bit("rst_errs", m0_err | m1_err, 1'b0);
        check_word("rst_io_addr", io_addr, '0);
        check_word("rst_io_wdata", io_wdata, '0);
        check_word("rst_io_size", 32'(io_byte_size), '0);
        model_last   = 1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        check_rdata("rst");
        rst = 1'b0;
    endtask

    // One complete transaction seen from the bus side, checked at fixed spec latencies.
    task automatic serve(input int delay, input int hold, input logic [XLEN-1:0] rd,
                         input bit raise_other, output int g);
        int o;
        g          = pick();
        o          = 1 - g;
        model_last = g;
        tick();
        check_bit("grant_busy", busy, 1'b1);
        check_bit("grant_io_read", io_read, !mst[g].write);
        check_bit("grant_io_write", io_write, mst[g].write);
        check_word("grant_io_addr", io_addr, mst[g].addr);
        check_word("grant_io_wdata", io_wdata, mst[g].wdata);
        check_word("grant_io_size", 32'(io_byte_size), 32'(mst[g].size));
        check_bit("grant_read_ready", read_ready, 1'b0);
        if (raise_other && !mst[o].req) new_req(o);
        for (int c = 1; c < delay; c++) begin
            tick();
            check_bit("wait_strobe", io_read | io_write, 1'b1);
            check_word("wait_io_addr", io_addr, mst[g].addr);
            check_bit("wait_acks", m0_ack | m1_ack, 1'b0);
        end
        io_rdata = rd;
        io_ready = 1'b1;
        tick();
        if (!mst[g].write) exp_rdata[g] = rd;
        check_bit("ack_granted", ack_of(g), 1'b1);
        check_bit("ack_other", ack_of(o), 1'b0);
        check_bit("ack_err", err_of(g), 1'b0);
        check_rdata("ack");
        check_bit("ack_read_ready", read_ready, 1'b1);
        check_bit("ack_strobe", io_read | io_write, 1'b0);
        check_bit("ack_busy", busy, 1'b1);
        mst[g].req = 1'b0;
        io_rdata   = $urandom;
        for (int c = 0; c < hold; c++) begin
            tick();
            check_bit("hold_read_ready", read_ready, 1'b1);
            check_bit("hold_strobe", io_read | io_write, 1'b0);
            check_bit("hold_acks", m0_ack | m1_ack, 1'b0);
        end
        io_ready = 1'b0;
        tick();
        check_quiet("release");
        check_rdata("release");
    endtask

    initial begin
        int g;
        int sel;
        int idle;

        for (int i = 0; i < 2; i++) mst[i] = '{req: 1'b0, write: 1'b0, addr: '0, wdata: '0, size: 2'd0};
        io_rdata = '0;
        io_ready = 1'b0;
        apply_reset();

        // m0 read, peripheral answers after 3 cycles
        mst[0] = '{req: 1'b1, write: 1'b0, addr: 32'h0000_1000, wdata: '0, size: 2'd2};
        serve(3, 0, 32'hDEAD_BEEF, 1'b0, g);
        check_word("tp1_grant", 32'(g), 32'd0);
        check_word("tp1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);

        // m1 write, then a back-to-back second m1 request
        mst[1] = '{req: 1'b1, write: 1'b1, addr: 32'h2000_0004, wdata: 32'h1234_5678, size: 2'd2};
        serve(2, 0, 32'hA5A5_A5A5, 1'b0, g);
        check_word("tp2_grant", 32'(g), 32'd1);
        check_word("tp2_m0_rdata_kept", m0_rdata, 32'hDEAD_BEEF);
        new_req(1);
        serve(1, 1, $urandom, 1'b0, g);
        check_word("b2b_grant", 32'(g), 32'd1);

        // both request together right after reset: grants alternate 0,1,0,1
        apply_reset();
        new_req(0);
        new_req(1);
        for (int i = 0; i < 4; i++) begin
            serve(int'($urandom_range(3, 1)), 0, $urandom, 1'b0, g);
            check_word("rr_order", 32'(g), 32'(i % 2));
            if (i < 2) new_req(g);
        end

        // io_ready held 4 cycles after completion while m1 waits
        new_req(0);
        mst[0].write = 1'b0;
        new_req(1);
        serve(2, 4, $urandom, 1'b0, g);
        check_word("hold_grant0", 32'(g), 32'd0);
        serve(1, 0, $urandom, 1'b0, g);
        check_word("hold_grant1", 32'(g), 32'd1);

        // reset in the middle of ACCESS drops the transfer without an ack
        new_req(0);
        tick();
        check_bit("mid_grant", io_read | io_write, 1'b1);
        tick();
        apply_reset();
        tick();
        check_quiet("post_rst");
        new_req(1);
        serve(2, 0, $urandom, 1'b0, g);
        check_word("post_rst_grant", 32'(g), 32'd1);

        // randomized traffic against the round-robin model
        for (int it = 0; it < 40; it++) begin
            if (!mst[0].req && !mst[1].req) begin
                idle = int'($urandom_range(2, 0));
                for (int k = 0; k < idle; k++) begin
                    tick();
                    check_quiet("idle_gap");
                end
                sel = int'($urandom_range(2, 0));
                if (sel != 1) new_req(0);
                if (sel != 0) new_req(1);
            end
            serve(int'($urandom_range(5, 1)), int'($urandom_range(3, 0)), $urandom,
                  bit'($urandom_range(1, 0)), g);
            if ($urandom_range(1, 0) == 1) new_req(g);
        end

`ifdef PBA_TIMEOUT_EN
        // watchdog: io_ready never arrives
        apply_reset();
        new_req(0);
        mst[0].write = 1'b0;
        tick();
        check_bit("to_grant", io_read, 1'b1);
        for (int c = 1; c < TOUT; c++) begin
            tick();
            check_bit("to_wait_strobe", io_read, 1'b1);
            check_bit("to_wait_ack", m0_ack, 1'b0);
        end
        tick();
        check_bit("to_ack", m0_ack, 1'b1);
        check_bit("to_err", m0_err, 1'b1);
        check_word("to_rdata", m0_rdata, '0);
        check_bit("to_read_ready", read_ready, 1'b0);
        check_bit("to_strobe", io_read, 1'b0);
        check_bit("to_busy", busy, 1'b0);
        mst[0].req = 1'b0;
        tick();
        check_quiet("to_after");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
